// File: rtl/vector_alu_wb.sv
// Vector execute/writeback stage: lane-wise 8-bit ALU with single-cycle ops and a
// 4-cycle, one-lane-per-cycle MUL. Drives the register file write port.
module vector_alu_wb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  input  logic [3:0]                    i_op,
  input  logic [3:0]                    i_rd,
  input  logic [DATA_WIDTH*LANES-1:0]   i_a,
  input  logic [DATA_WIDTH*LANES-1:0]   i_b,
  output logic                          o_ready,
  output logic                          o_we,
  output logic [3:0]                    o_w_addr,
  output logic [DATA_WIDTH*LANES-1:0]   o_w_data
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_MIN  = 4'd8,
    OP_MAX  = 4'd9,
    OP_ADDS = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e                        state;
  logic [1:0]                    cnt;
  logic [DATA_WIDTH*LANES-1:0]   mul_a;
  logic [DATA_WIDTH*LANES-1:0]   mul_b;
  logic [3:0]                    mul_rd;
  logic [DATA_WIDTH*LANES-1:0]   mul_res;
  logic [DATA_WIDTH*LANES-1:0]   alu_res;
  logic [DATA_WIDTH-1:0]         mul_lane;
  logic                          accept;
  logic                          single_op;

  function automatic logic [7:0] lane_op(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  lane_op = sum[7:0];
      OP_SUB:  lane_op = a - b;
      OP_AND:  lane_op = a & b;
      OP_OR:   lane_op = a | b;
      OP_XOR:  lane_op = a ^ b;
      OP_SHL:  lane_op = a << b[2:0];
      OP_SHR:  lane_op = a >> b[2:0];
      OP_MIN:  lane_op = (a < b) ? a : b;
      OP_MAX:  lane_op = (a > b) ? a : b;
      OP_ADDS: lane_op = sum[8] ? 8'hFF : sum[7:0];
      default: lane_op = '0;
    endcase
  endfunction

  always_comb begin
    alu_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      alu_res[DATA_WIDTH*i +: DATA_WIDTH] =
        lane_op(i_op, i_a[DATA_WIDTH*i +: DATA_WIDTH], i_b[DATA_WIDTH*i +: DATA_WIDTH]);
    end
  end

  assign o_ready   = (state == S_IDLE);
  assign accept    = i_valid && o_ready;
  assign single_op = (i_op >= OP_ADD) && (i_op <= OP_ADDS);
  assign mul_lane  = mul_a[DATA_WIDTH*cnt +: DATA_WIDTH] * mul_b[DATA_WIDTH*cnt +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_rd   <= '0;
      mul_res  <= '0;
      o_we     <= 1'b0;
      o_w_addr <= '0;
      o_w_data <= '0;
    end else begin
      o_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (i_op == OP_MUL) begin
              mul_a  <= i_a;
              mul_b  <= i_b;
              mul_rd <= i_rd;
              cnt    <= '0;
              state  <= S_MUL;
            end else if (single_op && (i_rd != 4'd0)) begin
              o_we     <= 1'b1;
              o_w_addr <= i_rd;
              o_w_data <= alu_res;
            end
          end
        end
        S_MUL: begin
          mul_res[DATA_WIDTH*cnt +: DATA_WIDTH] <= mul_lane;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // Last lane goes straight to the write port; the result register only holds lanes 0..2 in time.
            state <= S_IDLE;
            if (mul_rd != 4'd0) begin
              o_we     <= 1'b1;
              o_w_addr <= mul_rd;
              o_w_data <= {mul_lane, mul_res[DATA_WIDTH*3-1:0]};
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
